// File: rtl/packet_reassembler.sv
// rtl/packet_reassembler.sv - packs MTU-wide segments into big-endian AXI-Stream frames
// through an LCM-bit ring; tlast pads the packet out to the next frame boundary.
package packet_reassembler_pkg;
  function automatic int gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int lcm(input int a, input int b);
    return (a / gcd(a, b)) * b;
  endfunction
endpackage

module packet_reassembler
  import packet_reassembler_pkg::*;
#(
  parameter int MTU            = 64,
  parameter int AXI_FRAME_SIZE = 128,
  localparam int LCM           = lcm(MTU, AXI_FRAME_SIZE),
  localparam int FW            = $clog2(LCM) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MTU-1:0]            s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [AXI_FRAME_SIZE-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [FW-1:0]             fill_level
);

  localparam int NSLOT = LCM / AXI_FRAME_SIZE;
  localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int PW    = FW + 1;
  localparam logic [FW-1:0] LCM_W = FW'(LCM);
  localparam logic [FW-1:0] MTU_W = FW'(MTU);
  localparam logic [FW-1:0] AXI_W = FW'(AXI_FRAME_SIZE);

  logic [LCM-1:0]   ring;
  logic [LCM-1:0]   ring_next;
  logic [NSLOT-1:0] last_flag;
  logic [NSLOT-1:0] last_next;
  logic [FW-1:0]    wr_ptr;
  logic [SW-1:0]    rd_slot;
  logic [SW-1:0]    end_slot;
  logic [PW-1:0]    wr_end_u;
  logic [PW-1:0]    bound_u;
  logic [PW-1:0]    wr_sum;
  logic [FW-1:0]    wr_adv;
  logic [FW-1:0]    fill_next;
  logic [LCM-1:0]   wdata;
  logic [LCM-1:0]   wmask;
  logic [2*LCM-1:0] data_rot2;
  logic [2*LCM-1:0] mask_rot2;
  logic             in_acc;
  logic             out_acc;
  logic             slot_last;

  // Credit comes from registered occupancy only; a pop in the same cycle does not help.
  assign s_axis_tready = !rst && ((LCM_W - fill_level) >= MTU_W);
  assign m_axis_tvalid = !rst && (fill_level >= AXI_W);
  assign m_axis_tlast  = !rst && slot_last;
  assign in_acc        = s_axis_tvalid && s_axis_tready;
  assign out_acc       = m_axis_tvalid && m_axis_tready;

  // After padding the write pointer sits on a frame boundary, so segments can wrap the ring end.
  assign wr_end_u = PW'(wr_ptr) + PW'(MTU);

  always_comb begin
    bound_u  = PW'(AXI_FRAME_SIZE);
    end_slot = '0;
    for (int s = 1; s <= 2 * NSLOT; s++) begin
      if (wr_end_u > PW'((s - 1) * AXI_FRAME_SIZE) && wr_end_u <= PW'(s * AXI_FRAME_SIZE)) begin
        bound_u  = PW'(s * AXI_FRAME_SIZE);
        end_slot = SW'((s - 1) % NSLOT);
      end
    end
  end

  assign wr_adv = s_axis_tlast ? FW'(bound_u - PW'(wr_ptr)) : MTU_W;
  assign wr_sum = PW'(wr_ptr) + PW'(wr_adv);

  // Segment plus padding is laid out MSB-first, then rotated right to the write position.
  assign wdata     = LCM'(s_axis_tdata) << (LCM - MTU);
  assign wmask     = ~({LCM{1'b1}} >> wr_adv);
  assign data_rot2 = {wdata, wdata} >> wr_ptr;
  assign mask_rot2 = {wmask, wmask} >> wr_ptr;
  assign ring_next = in_acc ? ((ring & ~mask_rot2[LCM-1:0]) | data_rot2[LCM-1:0]) : ring;

  always_comb begin
    m_axis_tdata = '0;
    slot_last    = 1'b0;
    last_next    = last_flag;
    for (int s = 0; s < NSLOT; s++) begin
      if (rd_slot == SW'(s)) begin
        m_axis_tdata = ring[LCM-1-s*AXI_FRAME_SIZE -: AXI_FRAME_SIZE];
        slot_last    = last_flag[s];
        if (out_acc) last_next[s] = 1'b0;
      end
      if (in_acc && s_axis_tlast && end_slot == SW'(s)) last_next[s] = 1'b1;
    end
  end

  assign fill_next = fill_level + (in_acc ? wr_adv : '0) - (out_acc ? AXI_W : '0);

  always_ff @(posedge clk) begin
    ring <= ring_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_slot    <= '0;
      fill_level <= '0;
      last_flag  <= '0;
    end else begin
      if (in_acc) wr_ptr <= (wr_sum >= PW'(LCM)) ? FW'(wr_sum - PW'(LCM)) : FW'(wr_sum);
      if (out_acc) rd_slot <= (rd_slot == SW'(NSLOT - 1)) ? '0 : rd_slot + SW'(1);
      fill_level <= fill_next;
      last_flag  <= last_next;
    end
  end

`ifndef SYNTHESIS
  a_fill_bound: assert property (@(posedge clk) disable iff (rst) fill_level <= LCM_W);
  a_no_overrun: assert property (@(posedge clk) disable iff (rst) in_acc |-> ((LCM_W - fill_level) >= MTU_W));
`endif

endmodule
